// File: rtl/scan_display_ctrl.sv
// rtl/scan_display_ctrl.sv - time-multiplexed 7-segment scan controller with blanking and blink
//
// Purpose
//   Scans N_DIGITS common-anode digits one slot at a time. Each slot presents one BCD
//   digit (digit_code) to an external combinational segment decoder. The decoded
//   pattern (seg_in) is registered onto the pins with decimal point, leading-zero
//   blanking, invalid-code blanking and blink applied. The displayed digits and masks
//   are captured once per frame, so a frame is never torn by upstream updates.
//
// Ports
//   clk         in   1            system clock, rising edge
//   rst_n       in   1            synchronous reset, active-low
//   data_in     in   4*N_DIGITS   BCD digits, [3:0] = digit 0 (rightmost)
//   en_mask     in   N_DIGITS     1 = digit displayed
//   dp_mask     in   N_DIGITS     1 = decimal point lit
//   blink_mask  in   N_DIGITS     1 = digit dark during blink-off phase
//   lzb         in   1            1 = leading-zero blanking enabled
//   digit_code  out  4            BCD value of the current slot, to the decoder
//   seg_in      in   8            decoder output {a..g,dp}, active-low
//   seg         out  8            segment pins, active-low, bit0 = dp
//   an          out  N_DIGITS     anode select, active-low, one-hot or all-ones
//   frame_done  out  1            one-cycle pulse when the digit index wraps to 0

module scan_display_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   en_mask,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  lzb,
    output logic [3:0]            digit_code,
    input  logic [7:0]            seg_in,
    output logic [7:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(BLINK_FRAMES - 1);

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_e;

    // Scan state
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic             blink_ph_q, blink_ph_d;
    phase_e           phase_q, phase_d;

    // Per-frame shadow copy of everything that shapes the display
    logic [4*N_DIGITS-1:0] sh_data_q;
    logic [N_DIGITS-1:0]   sh_en_q;
    logic [N_DIGITS-1:0]   sh_dp_q;
    logic [N_DIGITS-1:0]   sh_blink_q;
    logic                  sh_lzb_q;

    // Registered pin drivers
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic                frame_done_q, frame_done_d;

    logic slot_end;
    logic frame_end;
    logic upper_zero;
    logic lz_blank;
    logic visible;

    assign slot_end  = (div_cnt_q == DIV_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    assign digit_code = sh_data_q[{idx_q, 2'b00} +: 4];

    // True when the current digit and every digit to its left are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int j = 0; j < N_DIGITS; j++) begin
            if ((IDX_W'(j) >= idx_q) && (sh_data_q[4*j +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    // Digit 0 is never leading-zero blanked so an all-zero value still shows "0".
    assign lz_blank = sh_lzb_q && (idx_q != '0) && upper_zero;

    assign visible = sh_en_q[idx_q]
                  && !(sh_blink_q[idx_q] && blink_ph_q)
                  && (digit_code <= 4'd9)
                  && !lz_blank;

    // Prescaler, digit index and blink timebase
    always_comb begin
        div_cnt_d    = div_cnt_q + 1'b1;
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;
        blink_ph_d   = blink_ph_q;
        frame_done_d = 1'b0;
        if (slot_end) begin
            div_cnt_d = '0;
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (frame_end) begin
            frame_done_d = 1'b1;
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Slot phase FSM: the phase register always mirrors div_cnt against BLANK_CYC,
    // giving dead time at every slot start while the decoder settles on the new code.
    always_comb begin
        phase_d = (div_cnt_d < BLANK_END) ? PH_BLANK : PH_SHOW;
        an_d    = '1;
        seg_d   = 8'hFF;
        case (phase_q)
            PH_BLANK: begin
                an_d  = '1;
                seg_d = 8'hFF;
            end
            PH_SHOW: begin
                if (visible) begin
                    an_d[idx_q] = 1'b0;
                    seg_d       = {seg_in[7:1], seg_in[0] & ~sh_dp_q[idx_q]};
                end
            end
            default: begin
                an_d  = '1;
                seg_d = 8'hFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            frame_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            phase_q      <= PH_BLANK;
            sh_data_q    <= '0;
            sh_en_q      <= '0;
            sh_dp_q      <= '0;
            sh_blink_q   <= '0;
            sh_lzb_q     <= 1'b0;
            an_q         <= '1;
            seg_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_ph_q   <= blink_ph_d;
            phase_q      <= phase_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            if (frame_end) begin
                sh_data_q  <= data_in;
                sh_en_q    <= en_mask;
                sh_dp_q    <= dp_mask;
                sh_blink_q <= blink_mask;
                sh_lzb_q   <= lzb;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// tb/tb_scan_display_ctrl.sv - randomized self-checking bench for scan_display_ctrl

module tb_scan_display_ctrl;

    localparam int N     = 8;
    localparam int C     = 4;
    localparam int BC    = 1;
    localparam int BF    = 2;
    localparam int FRAME = N * C;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  en;
        logic [7:0]  dp;
        logic [7:0]  blink;
        logic        lzb;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  en_mask = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  blink_mask = '0;
    logic        lzb = 1'b0;
    logic [3:0]  digit_code;
    logic [7:0]  seg_in;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        frame_done;

    logic [7:0]  seg_lut [16];
    snap_t       snap_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int s        = 0;
    bit live     = 1'b0;
    bit check_first = 1'b0;
    int last_fd  = -1;

    scan_display_ctrl #(
        .N_DIGITS    (N),
        .CLK_DIV     (C),
        .BLANK_CYC   (BC),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .en_mask    (en_mask),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .lzb        (lzb),
        .digit_code (digit_code),
        .seg_in     (seg_in),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Stand-in decoder: an arbitrary fixed pattern per code exposes any bit shuffling.
    assign seg_in = seg_lut[digit_code];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (state %0d)", tag, got, exp, s);
        end
    endtask

    // Advance one clock and compare against the reference. State index s counts
    // non-reset edges since the last reset; pins show state s-1, digit_code shows s.
    task automatic step();
        snap_t       sh;
        int          t, idx, dv, f;
        logic [3:0]  d;
        bit          vis, ph;
        logic [7:0]  e_an, e_seg;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            s = 0;
            snap_q.delete();
            snap_q.push_back('0);
            live    = 1'b1;
            last_fd = -1;
            check("rst_an", an, 8'hFF);
            check("rst_seg", seg, 8'hFF);
            check("rst_fd", frame_done, 0);
            check("rst_code", digit_code, 0);
            return;
        end
        if (!live) return;
        s++;
        if (s % FRAME == 0) snap_q.push_back({data_in, en_mask, dp_mask, blink_mask, lzb});

        t   = s - 1;
        dv  = t % C;
        idx = (t / C) % N;
        f   = t / FRAME;
        sh  = snap_q[f];
        ph  = ((f / BF) % 2) == 1;
        d   = 4'((sh.data >> (4 * idx)) & 32'hF);
        vis = sh.en[idx] && !(sh.blink[idx] && ph) && (d <= 4'd9)
              && !(sh.lzb && idx > 0 && (sh.data >> (4 * idx)) == 32'd0);
        if (dv < BC || !vis) begin
            e_an  = 8'hFF;
            e_seg = 8'hFF;
        end else begin
            e_an  = ~(8'h01 << idx);
            e_seg = {seg_lut[d][7:1], seg_lut[d][0] & ~sh.dp[idx]};
        end
        check("an", an, e_an);
        check("seg", seg, e_seg);
        check("frame_done", frame_done, (s % FRAME == 0) ? 1 : 0);
        check("an_onehot", ($countones(~an) <= 1) ? 1 : 0, 1);

        sh = snap_q[s / FRAME];
        check("digit_code", digit_code, (sh.data >> (4 * ((s / C) % N))) & 32'hF);

        if (check_first && an !== 8'hFF) begin
            check("first_lit", an, 8'hFE);
            check_first = 1'b0;
        end
        if (frame_done === 1'b1) begin
            if (last_fd >= 0) check("fd_period", s - last_fd, FRAME);
            last_fd = s;
        end
    endtask

    function automatic logic [31:0] rand_digits();
        logic [31:0] v;
        int r;
        v = '0;
        for (int i = 0; i < N; i++) begin
            r = $urandom_range(0, 19);
            if (r < 6)       v[4*i +: 4] = 4'd0;
            else if (r < 8)  v[4*i +: 4] = 4'($urandom_range(10, 15));
            else             v[4*i +: 4] = 4'($urandom_range(1, 9));
        end
        if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(1, 7));
        return v;
    endfunction

    initial begin
        bit found;
        for (int i = 0; i < 16; i++) seg_lut[i] = 8'($urandom);

        // Reset, then plain scan order
        data_in     = 32'h76543210;
        en_mask     = 8'hFF;
        check_first = 1'b1;
        rst_n       = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3 * FRAME) step();

        // Mid-frame update must wait for the next frame
        repeat (13) step();
        data_in = 32'h89012345;
        repeat (2 * FRAME) step();

        // Invalid code on digit 2, decimal point on digit 1
        data_in = 32'h76543A10;
        dp_mask = 8'h02;
        repeat (2 * FRAME) step();

        // Leading-zero blanking, then blink on digit 0
        data_in = 32'h00001234;
        dp_mask = 8'h00;
        lzb     = 1'b1;
        repeat (2 * FRAME) step();
        blink_mask = 8'h01;
        repeat (8 * FRAME) step();
        data_in    = 32'h0;
        blink_mask = 8'h00;
        dp_mask    = 8'h0C;
        repeat (2 * FRAME) step();

        // Randomized inputs changed at random points, occasional resets
        for (int it = 0; it < 80; it++) begin
            repeat ($urandom_range(1, 40)) step();
            data_in    = rand_digits();
            en_mask    = 8'($urandom | $urandom);
            dp_mask    = 8'($urandom);
            blink_mask = 8'($urandom & $urandom);
            lzb        = 1'($urandom);
            if ($urandom_range(0, 14) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end

        // Reset in the middle of slot 5
        data_in    = 32'h76543210;
        en_mask    = 8'hFF;
        dp_mask    = 8'h00;
        blink_mask = 8'h00;
        lzb        = 1'b0;
        found      = 1'b0;
        for (int k = 0; k < 4 * FRAME && !found; k++) begin
            step();
            if (s % C == 2 && (s / C) % N == 5) found = 1'b1;
        end
        check("slot5_reached", found, 1);
        check_first = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3 * FRAME) step();
        check("first_lit_seen", check_first, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
